// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame format,
// kept here so a receiver can reuse the same vocabulary.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_STOP_BITS = 1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SYNC,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Parity over up to 9 data bits; unused upper bits must be zero.
    function automatic logic parity_of(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and shifts it out
// LSB first, one bit per baud_tick, with optional parity and one or two stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = DEFAULT_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 srst_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int                CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);
    localparam logic              ODD       = (PARITY_ODD != 0);

    tx_state_e              state_q,    state_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic [CNT_W-1:0]       bit_cnt_q,  bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   parity_q,   parity_d;
    logic                   tx_q,       tx_d;
    logic                   done_q,     done_d;

    // NOTE: every register, including the shift register, is cleared by reset so an
    // aborted frame leaves no stale data behind; non-blocking assignments only here.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    // NOTE: all outputs of this block get a default first, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        done_d     = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                // A tick arriving with the handshake is ignored; SYNC waits for the next.
                if (tx_valid) begin
                    state_d    = TX_SYNC;
                    shift_d    = tx_data;
                    parity_d   = parity_of(9'(tx_data), ODD);
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            TX_SYNC: begin
                if (baud_tick) state_d = TX_START;
            end
            TX_START: begin
                if (baud_tick) begin
                    state_d   = TX_DATA;
                    bit_cnt_d = '0;
                end
            end
            TX_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (baud_tick) begin
                    state_d    = TX_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            TX_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = TX_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // The line level is decoded from the next state so tx changes with the state.
        case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = shift_d[0];
            TX_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx_ready = (state_q == TX_IDLE);
    assign tx_busy  = (state_q != TX_IDLE);
    assign tx       = tx_q;
    assign tx_done  = done_q;

endmodule
